// File: rtl/pdp8_pkg.sv
// Shared definitions for the PDP-8 fetch/indirect sequencer: state encoding,
// parameter legal ranges and the drive-phase classification helper.
package pdp8_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_IDLE   = 4'd0;
    localparam state_t S_F_CK   = 4'd1;
    localparam state_t S_F_STB  = 4'd2;
    localparam state_t S_DECODE = 4'd3;
`ifdef PDP8_AUTOINDEX_EN
    localparam state_t S_A1_CK  = 4'd4;
    localparam state_t S_A1_STB = 4'd5;
    localparam state_t S_A2_CK  = 4'd6;
    localparam state_t S_A2_STB = 4'd7;
`endif
    localparam state_t S_I_CK   = 4'd8;
    localparam state_t S_I_STB  = 4'd9;
    localparam state_t S_DONE   = 4'd10;

    localparam int CK_LEN_MIN   = 1;
    localparam int CK_LEN_MAX   = 15;
    localparam int WAIT_MAX_MIN = 1;
    localparam int WAIT_MAX_MAX = 255;

    // Wide enough that the longest legal phase (hold plus wait) never saturates early.
    localparam int PHASE_CNT_W = $clog2(CK_LEN_MAX + WAIT_MAX_MAX + 1);

    function automatic logic is_ck_state(input state_t s);
`ifdef PDP8_AUTOINDEX_EN
        return (s == S_F_CK) || (s == S_A1_CK) || (s == S_A2_CK) || (s == S_I_CK);
`else
        return (s == S_F_CK) || (s == S_I_CK);
`endif
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-phase clock counter: restarts on every state entry, saturates, and flags
// when the minimum drive hold has elapsed and when the ramReady wait has run out.
module phase_timer
    import pdp8_pkg::*;
#(
    parameter int CK_LEN   = 1,
    parameter int WAIT_MAX = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic hold_met,
    output logic wait_expired
);

    localparam logic [PHASE_CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [PHASE_CNT_W:0]   HOLD_AGE = (PHASE_CNT_W + 1)'(CK_LEN);
    localparam logic [PHASE_CNT_W:0]   WAIT_AGE = (PHASE_CNT_W + 1)'(CK_LEN + WAIT_MAX);

    logic [PHASE_CNT_W-1:0] cnt_q, cnt_d;
    logic [PHASE_CNT_W:0]   age;

    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // age is the 1-based clock count within the current phase.
    assign age          = {1'b0, cnt_q} + 1'b1;
    assign hold_met     = age >= HOLD_AGE;
    assign wait_expired = age >= WAIT_AGE;

endmodule

// File: rtl/fetch_ind_seq.sv
// PDP-8 instruction fetch / indirect-address sequencer (Moore FSM).
// Define PDP8_AUTOINDEX_EN to add the auto-index A1/A2 read-increment-write phases.
module fetch_ind_seq
    import pdp8_pkg::*;
#(
    parameter int CK_LEN   = 1,
    parameter int WAIT_MAX = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic instIsIND,
    input  logic instIsPPIND,
    input  logic ramReady,
    output logic pc_ck,
    output logic ir_ck,
    output logic ram_oe,
    output logic ram_we,
    output logic ir2rama,
    output logic ind_ck,
    output logic ind2inc,
    output logic inc2ramd,
    output logic busy,
    output logic done,
    output logic err
);

    state_t state_q, state_d;
    logic   err_q, err_d;
    logic   hold_met, wait_expired, ck_exit, ck_timeout;

    phase_timer #(
        .CK_LEN   (CK_LEN),
        .WAIT_MAX (WAIT_MAX)
    ) u_phase_timer (
        .clk          (clk),
        .reset        (reset),
        .restart      (state_d != state_q),
        .hold_met     (hold_met),
        .wait_expired (wait_expired)
    );

    assign ck_exit    = is_ck_state(state_q) && hold_met && ramReady;
    assign ck_timeout = is_ck_state(state_q) && !ck_exit && wait_expired;

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE:   if (start) state_d = S_F_CK;
            S_F_CK:   if (ck_exit) state_d = S_F_STB;
            S_F_STB:  state_d = S_DECODE;
`ifdef PDP8_AUTOINDEX_EN
            S_DECODE: begin
                if (instIsPPIND)    state_d = S_A1_CK;
                else if (instIsIND) state_d = S_I_CK;
                else                state_d = S_DONE;
            end
            S_A1_CK:  if (ck_exit) state_d = S_A1_STB;
            S_A1_STB: state_d = S_A2_CK;
            S_A2_CK:  if (ck_exit) state_d = S_A2_STB;
            S_A2_STB: state_d = S_I_CK;
`else
            // Without auto-index hardware a PPIND instruction is a plain indirect.
            S_DECODE: begin
                if (instIsIND || instIsPPIND) state_d = S_I_CK;
                else                          state_d = S_DONE;
            end
`endif
            S_I_CK:   if (ck_exit) state_d = S_I_STB;
            S_I_STB:  state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (ck_timeout) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments; the synchronous reset overrides all.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        pc_ck   = 1'b0;
        ir_ck   = 1'b0;
        ram_oe  = 1'b0;
        ir2rama = 1'b0;
        ind_ck  = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_F_CK:   ram_oe = 1'b1;
            S_F_STB:  begin pc_ck = 1'b1; ir_ck = 1'b1; end
`ifdef PDP8_AUTOINDEX_EN
            S_A1_CK:  begin ir2rama = 1'b1; ram_oe = 1'b1; end
            S_A1_STB: ind_ck = 1'b1;
            S_A2_CK,
            S_A2_STB: ir2rama = 1'b1;
`endif
            S_I_CK:   begin ir2rama = 1'b1; ram_oe = 1'b1; end
            S_I_STB:  begin ind_ck = 1'b1; ir2rama = 1'b1; end
            S_DONE:   done = 1'b1;
            default:  ;
        endcase
    end

`ifdef PDP8_AUTOINDEX_EN
    assign ind2inc  = (state_q == S_A1_CK) || (state_q == S_A2_CK);
    assign inc2ramd = (state_q == S_A2_CK) || (state_q == S_A2_STB);
    assign ram_we   = (state_q == S_A2_STB);
`else
    assign ind2inc  = 1'b0;
    assign inc2ramd = 1'b0;
    assign ram_we   = 1'b0;
`endif

    assign busy = (state_q != S_IDLE);
    assign err  = err_q;

endmodule

// File: tb/tb_fetch_ind_seq.sv
// Bench for fetch_ind_seq: a directed vector table, hand-built multi-clock corner
// sequences and randomized traffic, all checked against a phase-plan reference model.
module tb_fetch_ind_seq;

`ifdef PDP8_AUTOINDEX_EN
    localparam bit AUTOIDX = 1'b1;
`else
    localparam bit AUTOIDX = 1'b0;
`endif

    // Output vector layout: {pc_ck, ir_ck, ram_oe, ram_we, ir2rama, ind_ck, ind2inc, inc2ramd, busy, done, err}
    localparam logic [10:0] O_PC   = 11'h400;
    localparam logic [10:0] O_IR   = 11'h200;
    localparam logic [10:0] O_OE   = 11'h100;
    localparam logic [10:0] O_WE   = 11'h080;
    localparam logic [10:0] O_IRA  = 11'h040;
    localparam logic [10:0] O_IND  = 11'h020;
    localparam logic [10:0] O_I2I  = 11'h010;
    localparam logic [10:0] O_I2D  = 11'h008;
    localparam logic [10:0] O_BUSY = 11'h004;
    localparam logic [10:0] O_DONE = 11'h002;
    localparam logic [10:0] O_ERR  = 11'h001;

    typedef enum int {P_IDLE, P_FCK, P_FSTB, P_DEC, P_A1CK, P_A1STB, P_A2CK, P_A2STB,
                      P_ICK, P_ISTB, P_DONE} phase_e;

    typedef struct packed {
        logic        rst;
        logic        st;
        logic        ind;
        logic        pp;
        logic        rdy;
        logic [10:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic [1:0]  rst_v = 2'b11, st_v = 2'b00, ind_v = 2'b00, pp_v = 2'b00, rdy_v = 2'b00;
    wire  [10:0] out_a, out_b;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: instance 0 is CK_LEN=1/WAIT_MAX=8, instance 1 is CK_LEN=3/WAIT_MAX=4.
    int     ck_len   [2] = '{1, 3};
    int     wait_max [2] = '{8, 4};
    phase_e cur      [2];
    int     age      [2];
    bit     err_m    [2];
    phase_e plan     [2][12];
    int     plan_len [2];
    int     plan_pos [2];

    vec_t        tbl [18];
    logic [10:0] tr  [0:20];

    always #5 clk = ~clk;

    fetch_ind_seq #(.CK_LEN(1), .WAIT_MAX(8)) dut_a (
        .clk(clk), .reset(rst_v[0]), .start(st_v[0]), .instIsIND(ind_v[0]),
        .instIsPPIND(pp_v[0]), .ramReady(rdy_v[0]),
        .pc_ck(out_a[10]), .ir_ck(out_a[9]), .ram_oe(out_a[8]), .ram_we(out_a[7]),
        .ir2rama(out_a[6]), .ind_ck(out_a[5]), .ind2inc(out_a[4]), .inc2ramd(out_a[3]),
        .busy(out_a[2]), .done(out_a[1]), .err(out_a[0])
    );

    fetch_ind_seq #(.CK_LEN(3), .WAIT_MAX(4)) dut_b (
        .clk(clk), .reset(rst_v[1]), .start(st_v[1]), .instIsIND(ind_v[1]),
        .instIsPPIND(pp_v[1]), .ramReady(rdy_v[1]),
        .pc_ck(out_b[10]), .ir_ck(out_b[9]), .ram_oe(out_b[8]), .ram_we(out_b[7]),
        .ir2rama(out_b[6]), .ind_ck(out_b[5]), .ind2inc(out_b[4]), .inc2ramd(out_b[3]),
        .busy(out_b[2]), .done(out_b[1]), .err(out_b[0])
    );

    function automatic logic [10:0] phase_out(input phase_e p);
        case (p)
            P_FCK:   return O_OE | O_BUSY;
            P_FSTB:  return O_PC | O_IR | O_BUSY;
            P_DEC:   return O_BUSY;
            P_A1CK:  return O_IRA | O_OE | O_I2I | O_BUSY;
            P_A1STB: return O_IND | O_BUSY;
            P_A2CK:  return O_IRA | O_I2I | O_I2D | O_BUSY;
            P_A2STB: return O_WE | O_I2D | O_IRA | O_BUSY;
            P_ICK:   return O_IRA | O_OE | O_BUSY;
            P_ISTB:  return O_IND | O_IRA | O_BUSY;
            P_DONE:  return O_DONE | O_BUSY;
            default: return 11'h000;
        endcase
    endfunction

    function automatic bit is_ck(input phase_e p);
        return (p == P_FCK) || (p == P_A1CK) || (p == P_A2CK) || (p == P_ICK);
    endfunction

    function automatic vec_t mk(input logic r, s, ii, p, rd, input logic [10:0] e);
        vec_t v;
        v.rst = r; v.st = s; v.ind = ii; v.pp = p; v.rdy = rd; v.exp = e;
        return v;
    endfunction

    task automatic push(input bit i, input phase_e p);
        plan[i][plan_len[i]] = p;
        plan_len[i]++;
    endtask

    // One clock of the model: a sequence is a plan of phases, extended once the decode
    // inputs are seen; drive phases stretch for ramReady or give up after the wait budget.
    task automatic model_step(input bit i);
        if (rst_v[i]) begin
            cur[i] = P_IDLE; age[i] = 1; err_m[i] = 1'b0; plan_len[i] = 0; plan_pos[i] = 0;
            return;
        end
        err_m[i] = 1'b0;
        if (cur[i] == P_IDLE) begin
            if (st_v[i]) begin
                plan_len[i] = 0;
                push(i, P_FCK); push(i, P_FSTB); push(i, P_DEC);
                plan_pos[i] = 0; cur[i] = P_FCK; age[i] = 1;
            end
            return;
        end
        if (is_ck(cur[i]) && !(age[i] >= ck_len[i] && rdy_v[i])) begin
            if (age[i] >= ck_len[i] + wait_max[i]) begin
                cur[i] = P_IDLE; err_m[i] = 1'b1;
            end else begin
                age[i]++;
            end
            return;
        end
        if (cur[i] == P_DEC) begin
            if (AUTOIDX && pp_v[i]) begin
                push(i, P_A1CK); push(i, P_A1STB); push(i, P_A2CK); push(i, P_A2STB);
            end
            if (pp_v[i] || ind_v[i]) begin
                push(i, P_ICK); push(i, P_ISTB);
            end
            push(i, P_DONE);
        end
        plan_pos[i]++;
        cur[i] = (plan_pos[i] < plan_len[i]) ? plan[i][plan_pos[i]] : P_IDLE;
        age[i] = 1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic step(input logic [1:0] r, s, ii, p, rd);
        rst_v = r; st_v = s; ind_v = ii; pp_v = p; rdy_v = rd;
        @(posedge clk);
        model_step(1'b0);
        model_step(1'b1);
        #1;
        check("model_a", out_a, phase_out(cur[0]) | (err_m[0] ? O_ERR : 11'h000));
        check("model_b", out_b, phase_out(cur[1]) | (err_m[1] ? O_ERR : 11'h000));
    endtask

    // Drive one instance for a clock while the other is held in reset.
    task automatic drive1(input bit i, input logic r, s, ii, p, rd, output logic [10:0] o);
        logic [1:0] rv, sv, iv, pv, dv;
        rv = 2'b11; sv = 2'b00; iv = 2'b00; pv = 2'b00; dv = 2'b00;
        rv[i] = r; sv[i] = s; iv[i] = ii; pv[i] = p; dv[i] = rd;
        step(rv, sv, iv, pv, dv);
        o = (i == 1'b0) ? out_a : out_b;
    endtask

    initial begin
        logic [10:0] o;
        logic [1:0]  rr, ss, ii, pp, rd;
        int cnt_a, cnt_b, cnt_c, at_a, at_b;
        int rdy_pct, rc;

        // Directed table on instance 0 (CK_LEN=1): reset, plain fetch, ready stretch,
        // indirect path, start ignored while busy, reset mid-sequence.
        tbl[0]  = mk(1, 0, 0, 0, 0, 11'h000);
        tbl[1]  = mk(1, 1, 0, 0, 1, 11'h000);
        tbl[2]  = mk(0, 1, 0, 0, 1, O_OE | O_BUSY);
        tbl[3]  = mk(0, 1, 0, 0, 1, O_PC | O_IR | O_BUSY);
        tbl[4]  = mk(0, 1, 0, 0, 1, O_BUSY);
        tbl[5]  = mk(0, 1, 0, 0, 1, O_DONE | O_BUSY);
        tbl[6]  = mk(0, 1, 0, 0, 1, 11'h000);
        tbl[7]  = mk(0, 1, 0, 0, 0, O_OE | O_BUSY);
        tbl[8]  = mk(0, 0, 0, 0, 0, O_OE | O_BUSY);
        tbl[9]  = mk(0, 0, 0, 0, 1, O_PC | O_IR | O_BUSY);
        tbl[10] = mk(0, 0, 0, 0, 1, O_BUSY);
        tbl[11] = mk(0, 0, 1, 0, 1, O_IRA | O_OE | O_BUSY);
        tbl[12] = mk(0, 0, 0, 0, 1, O_IND | O_IRA | O_BUSY);
        tbl[13] = mk(0, 0, 0, 0, 1, O_DONE | O_BUSY);
        tbl[14] = mk(0, 0, 0, 0, 1, 11'h000);
        tbl[15] = mk(0, 1, 0, 0, 1, O_OE | O_BUSY);
        tbl[16] = mk(1, 1, 0, 0, 1, 11'h000);
        tbl[17] = mk(0, 0, 0, 0, 1, 11'h000);

        for (int k = 0; k < 18; k++) begin
            drive1(1'b0, tbl[k].rst, tbl[k].st, tbl[k].ind, tbl[k].pp, tbl[k].rdy, o);
            check($sformatf("vec%0d", k), o, tbl[k].exp);
        end

        // Auto-index instruction on instance 0; start presented in clock 1.
        drive1(1'b0, 1, 0, 0, 0, 1, o);
        drive1(1'b0, 0, 1, 0, 1, 1, tr[2]);
        for (int k = 3; k <= 14; k++) drive1(1'b0, 0, 0, 0, 1, 1, tr[k]);
        cnt_a = 0; cnt_b = 0; at_a = 0; at_b = 0;
        for (int k = 2; k <= 14; k++) begin
            if ((tr[k] & O_WE) != 0) begin cnt_a++; at_a = k; end
            if ((tr[k] & O_IND) != 0) cnt_b++;
            if ((tr[k] & O_DONE) != 0 && at_b == 0) at_b = k;
        end
        check("ppind_we_count", cnt_a, AUTOIDX ? 1 : 0);
        check("ppind_we_clock", at_a, AUTOIDX ? 8 : 0);
        check("ppind_indck_count", cnt_b, AUTOIDX ? 2 : 1);
        check("ppind_done_clock", at_b, AUTOIDX ? 11 : 7);

        // Instance 1 (CK_LEN=3): ramReady withheld two extra clocks in I_CK.
        drive1(1'b1, 1, 0, 0, 0, 1, o);
        drive1(1'b1, 0, 1, 1, 0, 1, tr[2]);
        for (int k = 2; k <= 14; k++) drive1(1'b1, 0, 0, 1, 0, !(k == 9 || k == 10), tr[k + 1]);
        cnt_a = 0; at_a = 0; at_b = 0; rc = 0;
        for (int k = 2; k <= 15; k++) begin
            if ((tr[k] & (O_IRA | O_OE)) == (O_IRA | O_OE)) begin
                cnt_a++; rc = k;
                if (at_a == 0) at_a = k;
            end
            if ((tr[k] & O_DONE) != 0 && at_b == 0) at_b = k;
        end
        check("ick_stretch_len", cnt_a, 5);
        check("ick_first_clock", at_a, 7);
        check("ick_last_clock", rc, 11);
        check("ick_done_clock", at_b, 13);

        // Instance 1 (WAIT_MAX=4): ramReady never arrives in F_CK -> timeout.
        drive1(1'b1, 1, 0, 0, 0, 0, o);
        drive1(1'b1, 0, 1, 0, 0, 0, tr[2]);
        for (int k = 2; k <= 12; k++) drive1(1'b1, 0, 0, 0, 0, 0, tr[k + 1]);
        cnt_a = 0; cnt_b = 0; cnt_c = 0; at_a = 0;
        for (int k = 2; k <= 13; k++) begin
            if ((tr[k] & O_BUSY) != 0) cnt_a++;
            if ((tr[k] & O_ERR) != 0) begin cnt_b++; at_a = k; end
            if ((tr[k] & O_DONE) != 0) cnt_c++;
        end
        check("timeout_busy_clocks", cnt_a, 7);
        check("timeout_err_count", cnt_b, 1);
        check("timeout_err_clock", at_a, 9);
        check("timeout_err_only", tr[9], O_ERR);
        check("timeout_no_done", cnt_c, 0);

        // Same instance, ramReady arrives on the very last allowed clock: no timeout.
        drive1(1'b1, 1, 0, 0, 0, 0, o);
        drive1(1'b1, 0, 1, 0, 0, 0, tr[2]);
        for (int k = 2; k <= 12; k++) drive1(1'b1, 0, 0, 0, 0, (k >= 8), tr[k + 1]);
        cnt_b = 0; at_b = 0;
        for (int k = 2; k <= 13; k++) begin
            if ((tr[k] & O_ERR) != 0) cnt_b++;
            if ((tr[k] & O_DONE) != 0 && at_b == 0) at_b = k;
        end
        check("late_ready_no_err", cnt_b, 0);
        check("late_ready_fstb", tr[9], O_PC | O_IR | O_BUSY);
        check("late_ready_done_clock", at_b, 11);

        // Reset in the middle of the longest sequence (A2_CK when auto-index exists).
        rc = AUTOIDX ? 7 : 5;
        drive1(1'b0, 1, 0, 0, 0, 1, o);
        drive1(1'b0, 0, 1, 0, 1, 1, tr[2]);
        for (int k = 2; k <= rc + 1; k++) drive1(1'b0, (k == rc), 0, 0, 1, 1, tr[k + 1]);
        cnt_a = 0;
        for (int k = 2; k <= rc + 2; k++) if ((tr[k] & O_WE) != 0) cnt_a++;
        check("reset_phase", tr[rc], AUTOIDX ? (O_IRA | O_I2I | O_I2D | O_BUSY) : (O_IRA | O_OE | O_BUSY));
        check("reset_next", tr[rc + 1], 11'h000);
        check("reset_stays_idle", tr[rc + 2], 11'h000);
        check("reset_no_write", cnt_a, 0);

        // Randomized traffic on both instances, ramReady density varied in bands.
        for (int n = 0; n < 4000; n++) begin
            rdy_pct = ((n / 500) % 3 == 0) ? 90 : (((n / 500) % 3 == 1) ? 50 : 15);
            for (int j = 0; j < 2; j++) begin
                rr[j] = ($urandom_range(0, 99) < 2);
                ss[j] = ($urandom_range(0, 99) < 30);
                ii[j] = $urandom_range(0, 1) != 0;
                pp[j] = $urandom_range(0, 1) != 0;
                rd[j] = ($urandom_range(0, 99) < rdy_pct);
            end
            step(rr, ss, ii, pp, rd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
